// File: rtl/dpram_pkg.sv
// Shared types and helpers for the byte-enable dual-port RAM.
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Contents: sequencer state encoding, read-during-write mode constants,
// lane-count helper and the per-lane merge used by both ports.
package dpram_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } dpram_state_e;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  // The merge helper works on a fixed maximum width so one function serves
  // any DATA/BYTE combination. Callers cast to and from MERGE_W.
  localparam int MERGE_W     = 1024;
  localparam int MERGE_IDX_W = $clog2(MERGE_W);

  function automatic int lanes(input int data_w, input int byte_w);
    return data_w / byte_w;
  endfunction

  // Take new_w on lanes whose be bit is set, old_w everywhere else.
  function automatic logic [MERGE_W-1:0] byte_merge(
    input logic [MERGE_W-1:0] old_w,
    input logic [MERGE_W-1:0] new_w,
    input logic [MERGE_W-1:0] be,
    input int                 byte_w
  );
    logic [MERGE_W-1:0]     res;
    logic [MERGE_IDX_W-1:0] bi;
    logic [MERGE_IDX_W-1:0] li;
    res = old_w;
    for (int i = 0; i < MERGE_W; i++) begin
      bi = MERGE_IDX_W'(i);
      li = MERGE_IDX_W'(i / byte_w);
      if (be[li]) res[bi] = new_w[bi];
    end
    return res;
  endfunction

endpackage

// File: rtl/dpram_init_seq.sv
// Post-reset fill sequencer: walks every address once, then parks in RUN.
// Latency: 2**ADDR cycles of busy after reset release.
// Backpressure: none; ports are locked out by the top while busy.
//
// Ports: clK, rst_N (sync, active low) in; init_busy, init_we, init_addr out.
module dpram_init_seq
  import dpram_pkg::*;
#(
  parameter int ADDR = 5
) (
  input  logic            clK,
  input  logic            rst_N,
  output logic            init_busy,
  output logic            init_we,
  output logic [ADDR-1:0] init_addr
);

  dpram_state_e    state_q, state_d;
  logic [ADDR-1:0] cnt_q, cnt_d;

  always_ff @(posedge clK) begin
    if (!rst_N) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    init_we   = 1'b0;
    init_busy = (state_q == ST_INIT);
    init_addr = cnt_q;
    case (state_q)
      ST_INIT: begin
        // Held off while reset is asserted so the restart is clean.
        init_we = rst_N;
        cnt_d   = cnt_q + ADDR'(1);
        if (cnt_q == {ADDR{1'b1}}) state_d = ST_RUN;
      end
      ST_RUN:  ;
      default: state_d = ST_INIT;
    endcase
  end

endmodule

// File: rtl/dpram_be_init.sv
// True dual-port RAM with byte enables, RDW mode, collision flag and self-init.
// Latency: read data/VALID 1 cycle after EN (2 with OUT_REG=1), fully pipelined.
// Backpressure: none; ports are ignored while init_busy is high.
//
// Ports: clK, rst_N; per port X in {a,b}: X_port_EN/WR/BE/ADDR/data_IN in,
// X_port_data_OUT/VALID out; collision and init_busy out.
module dpram_be_init
  import dpram_pkg::*;
#(
  parameter int              DATA     = 16,
  parameter int              ADDR     = 5,
  parameter int              BYTE     = 8,
  parameter int              RDW_MODE = RDW_READ_FIRST,
  parameter int              OUT_REG  = 0,
  parameter logic [DATA-1:0] INIT_VAL = '0
) (
  input  logic                 clK,
  input  logic                 rst_N,
  output logic                 init_busy,
  input  logic                 a_port_EN,
  input  logic                 a_port_WR,
  input  logic [DATA/BYTE-1:0] a_port_BE,
  input  logic [ADDR-1:0]      a_port_ADDR,
  input  logic [DATA-1:0]      a_port_data_IN,
  output logic [DATA-1:0]      a_port_data_OUT,
  output logic                 a_port_VALID,
  input  logic                 b_port_EN,
  input  logic                 b_port_WR,
  input  logic [DATA/BYTE-1:0] b_port_BE,
  input  logic [ADDR-1:0]      b_port_ADDR,
  input  logic [DATA-1:0]      b_port_data_IN,
  output logic [DATA-1:0]      b_port_data_OUT,
  output logic                 b_port_VALID,
  output logic                 collision
);

  localparam int LANES = lanes(DATA, BYTE);
  localparam int DEPTH = 2 ** ADDR;

  logic [DATA-1:0] mem [DEPTH];

  logic            init_we;
  logic [ADDR-1:0] init_addr;

  dpram_init_seq #(.ADDR(ADDR)) u_init_seq (
    .clK       (clK),
    .rst_N     (rst_N),
    .init_busy (init_busy),
    .init_we   (init_we),
    .init_addr (init_addr)
  );

  // Port accesses only count in RUN and never on a reset edge.
  logic run_acc;
  assign run_acc = !init_busy && rst_N;

  logic             a_acc, b_acc;
  logic [LANES-1:0] a_be_wr, b_be_wr;
  logic [LANES-1:0] a_we_lane, b_we_lane;
  logic [DATA-1:0]  a_old, b_old, a_merged, b_merged, a_rd, b_rd;
  logic             col_now;

  always_comb begin
    a_acc     = run_acc && a_port_EN;
    b_acc     = run_acc && b_port_EN;
    a_be_wr   = a_port_WR ? a_port_BE : '0;
    b_be_wr   = b_port_WR ? b_port_BE : '0;
    a_we_lane = a_acc ? a_be_wr : '0;
    b_we_lane = b_acc ? b_be_wr : '0;

    // The array read is pre-edge, so a port that is not writing naturally
    // sees the old word even when the other port writes the same address.
    a_old    = mem[a_port_ADDR];
    b_old    = mem[b_port_ADDR];
    a_merged = DATA'(byte_merge(MERGE_W'(a_old), MERGE_W'(a_port_data_IN),
                                MERGE_W'(a_be_wr), BYTE));
    b_merged = DATA'(byte_merge(MERGE_W'(b_old), MERGE_W'(b_port_data_IN),
                                MERGE_W'(b_be_wr), BYTE));
    a_rd     = (RDW_MODE == RDW_WRITE_FIRST) ? a_merged : a_old;
    b_rd     = (RDW_MODE == RDW_WRITE_FIRST) ? b_merged : b_old;

    col_now  = a_acc && b_acc && (a_port_ADDR == b_port_ADDR)
               && (a_port_WR || b_port_WR);
  end

  // Port B lanes are scheduled before port A so A's assignment wins on any
  // lane both ports write at the same address.
  always_ff @(posedge clK) begin
    if (init_we) begin
      mem[init_addr] <= INIT_VAL;
    end else begin
      for (int l = 0; l < LANES; l++) begin
        if (b_we_lane[l]) mem[b_port_ADDR][l*BYTE +: BYTE] <= b_port_data_IN[l*BYTE +: BYTE];
        if (a_we_lane[l]) mem[a_port_ADDR][l*BYTE +: BYTE] <= a_port_data_IN[l*BYTE +: BYTE];
      end
    end
  end

  // First read stage: data holds when there is no read.
  logic            a_vld1, b_vld1, col1;
  logic [DATA-1:0] a_dat1, b_dat1;

  always_ff @(posedge clK) begin
    if (!rst_N) begin
      a_vld1 <= 1'b0;
      b_vld1 <= 1'b0;
      col1   <= 1'b0;
      a_dat1 <= '0;
      b_dat1 <= '0;
    end else begin
      a_vld1 <= a_acc;
      b_vld1 <= b_acc;
      col1   <= col_now;
      if (a_acc) a_dat1 <= a_rd;
      if (b_acc) b_dat1 <= b_rd;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic            a_vld2, b_vld2, col2;
    logic [DATA-1:0] a_dat2, b_dat2;

    always_ff @(posedge clK) begin
      if (!rst_N) begin
        a_vld2 <= 1'b0;
        b_vld2 <= 1'b0;
        col2   <= 1'b0;
        a_dat2 <= '0;
        b_dat2 <= '0;
      end else begin
        a_vld2 <= a_vld1;
        b_vld2 <= b_vld1;
        col2   <= col1;
        if (a_vld1) a_dat2 <= a_dat1;
        if (b_vld1) b_dat2 <= b_dat1;
      end
    end

    assign a_port_VALID    = a_vld2;
    assign b_port_VALID    = b_vld2;
    assign collision       = col2;
    assign a_port_data_OUT = a_dat2;
    assign b_port_data_OUT = b_dat2;
  end else begin : g_no_out_reg
    assign a_port_VALID    = a_vld1;
    assign b_port_VALID    = b_vld1;
    assign collision       = col1;
    assign a_port_data_OUT = a_dat1;
    assign b_port_data_OUT = b_dat1;
  end

endmodule

// File: tb/tb_dpram_be_init.sv
// Directed bench: three DUT copies share stimulus.
// u[0]: read-first, no out reg; u[1]: write-first; u[2]: read-first, out reg.
module tb_dpram_be_init;

  logic        clK = 1'b0;
  logic        rst_N;
  logic        a_en, a_wr, b_en, b_wr;
  logic [1:0]  a_be, b_be;
  logic [4:0]  a_addr, b_addr;
  logic [15:0] a_din, b_din;

  logic        busy [3];
  logic [15:0] a_do [3];
  logic [15:0] b_do [3];
  logic        a_v  [3];
  logic        b_v  [3];
  logic        col  [3];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clK = ~clK;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dpram_be_init #(
      .DATA(16), .ADDR(5), .BYTE(8),
      .RDW_MODE((g == 1) ? 1 : 0),
      .OUT_REG((g == 2) ? 1 : 0),
      .INIT_VAL(16'h0000)
    ) u_dut (
      .clK             (clK),
      .rst_N           (rst_N),
      .init_busy       (busy[g]),
      .a_port_EN       (a_en),
      .a_port_WR       (a_wr),
      .a_port_BE       (a_be),
      .a_port_ADDR     (a_addr),
      .a_port_data_IN  (a_din),
      .a_port_data_OUT (a_do[g]),
      .a_port_VALID    (a_v[g]),
      .b_port_EN       (b_en),
      .b_port_WR       (b_wr),
      .b_port_BE       (b_be),
      .b_port_ADDR     (b_addr),
      .b_port_data_IN  (b_din),
      .b_port_data_OUT (b_do[g]),
      .b_port_VALID    (b_v[g]),
      .collision       (col[g])
    );
  end

  typedef struct {
    logic        a_en, a_wr; logic [1:0] a_be; logic [4:0] a_addr; logic [15:0] a_din;
    logic        b_en, b_wr; logic [1:0] b_be; logic [4:0] b_addr; logic [15:0] b_din;
    logic        xa_vld; logic [15:0] xa0, xa1;   // expected A: valid, read-first, write-first
    logic        xb_vld; logic [15:0] xb0, xb1;
    logic        xcol;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];
  vec_t prev;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    a_en = v.a_en; a_wr = v.a_wr; a_be = v.a_be; a_addr = v.a_addr; a_din = v.a_din;
    b_en = v.b_en; b_wr = v.b_wr; b_be = v.b_be; b_addr = v.b_addr; b_din = v.b_din;
  endtask

  task automatic idle();
    a_en = 0; a_wr = 0; a_be = 0; a_addr = 0; a_din = 0;
    b_en = 0; b_wr = 0; b_be = 0; b_addr = 0; b_din = 0;
  endtask

  // Called at the negedge of reset release; counts busy samples from there.
  // Also records any VALID/collision activity seen while busy.
  task automatic count_busy(output int n, output int noisy);
    n = 0;
    noisy = 0;
    for (int i = 0; i < 200; i++) begin
      if (!busy[0]) break;
      n++;
      for (int g = 0; g < 3; g++)
        if (a_v[g] || b_v[g] || col[g]) noisy++;
      @(negedge clK);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n, noisy;

    tbl[0]  = '{1,0,2'b00,5'd31,16'h0000, 0,0,2'b00,5'd0,16'h0000, 1,16'h0000,16'h0000, 0,16'h0000,16'h0000, 0};
    tbl[1]  = '{1,1,2'b11,5'd3,16'hABCD,  0,0,2'b00,5'd0,16'h0000, 1,16'h0000,16'hABCD, 0,16'h0000,16'h0000, 0};
    tbl[2]  = '{1,1,2'b01,5'd3,16'h1234,  0,0,2'b00,5'd0,16'h0000, 1,16'hABCD,16'hAB34, 0,16'h0000,16'h0000, 0};
    tbl[3]  = '{1,0,2'b00,5'd3,16'h0000,  0,0,2'b00,5'd0,16'h0000, 1,16'hAB34,16'hAB34, 0,16'h0000,16'h0000, 0};
    tbl[4]  = '{1,1,2'b11,5'd5,16'h1111,  0,0,2'b00,5'd0,16'h0000, 1,16'h0000,16'h1111, 0,16'h0000,16'h0000, 0};
    tbl[5]  = '{1,1,2'b11,5'd5,16'h2222,  0,0,2'b00,5'd0,16'h0000, 1,16'h1111,16'h2222, 0,16'h0000,16'h0000, 0};
    tbl[6]  = '{1,0,2'b00,5'd5,16'h0000,  0,0,2'b00,5'd0,16'h0000, 1,16'h2222,16'h2222, 0,16'h0000,16'h0000, 0};
    tbl[7]  = '{1,1,2'b01,5'd7,16'hAAAA,  1,1,2'b11,5'd7,16'hBBBB, 1,16'h0000,16'h00AA, 1,16'h0000,16'hBBBB, 1};
    tbl[8]  = '{1,0,2'b00,5'd7,16'h0000,  1,0,2'b00,5'd7,16'h0000, 1,16'hBBAA,16'hBBAA, 1,16'hBBAA,16'hBBAA, 0};
    tbl[9]  = '{0,0,2'b00,5'd0,16'h0000,  0,0,2'b00,5'd0,16'h0000, 0,16'hBBAA,16'hBBAA, 0,16'hBBAA,16'hBBAA, 0};
    tbl[10] = '{1,0,2'b00,5'd3,16'h0000,  1,1,2'b10,5'd3,16'h5678, 1,16'hAB34,16'hAB34, 1,16'hAB34,16'h5634, 1};
    tbl[11] = '{1,1,2'b00,5'd9,16'hFFFF,  1,0,2'b00,5'd3,16'h0000, 1,16'h0000,16'h0000, 1,16'h5634,16'h5634, 0};
    tbl[12] = '{1,0,2'b00,5'd9,16'h0000,  0,0,2'b00,5'd0,16'h0000, 1,16'h0000,16'h0000, 0,16'h5634,16'h5634, 0};
    tbl[13] = '{0,0,2'b00,5'd0,16'h0000,  1,1,2'b11,5'd0,16'h0010, 0,16'h0000,16'h0000, 1,16'h0000,16'h0010, 0};
    tbl[14] = '{0,0,2'b00,5'd0,16'h0000,  1,1,2'b11,5'd1,16'h0011, 0,16'h0000,16'h0000, 1,16'h0000,16'h0011, 0};
    tbl[15] = '{0,0,2'b00,5'd0,16'h0000,  1,1,2'b11,5'd2,16'h0012, 0,16'h0000,16'h0000, 1,16'h0000,16'h0012, 0};
    tbl[16] = '{0,0,2'b00,5'd0,16'h0000,  1,1,2'b11,5'd3,16'h0013, 0,16'h0000,16'h0000, 1,16'h5634,16'h0013, 0};
    tbl[17] = '{0,0,2'b00,5'd0,16'h0000,  1,0,2'b00,5'd0,16'h0000, 0,16'h0000,16'h0000, 1,16'h0010,16'h0010, 0};
    tbl[18] = '{0,0,2'b00,5'd0,16'h0000,  1,0,2'b00,5'd1,16'h0000, 0,16'h0000,16'h0000, 1,16'h0011,16'h0011, 0};
    tbl[19] = '{0,0,2'b00,5'd0,16'h0000,  1,0,2'b00,5'd2,16'h0000, 0,16'h0000,16'h0000, 1,16'h0012,16'h0012, 0};
    tbl[20] = '{0,0,2'b00,5'd0,16'h0000,  1,0,2'b00,5'd3,16'h0000, 0,16'h0000,16'h0000, 1,16'h0013,16'h0013, 0};
    tbl[21] = '{0,0,2'b00,5'd0,16'h0000,  0,0,2'b00,5'd0,16'h0000, 0,16'h0000,16'h0000, 0,16'h0013,16'h0013, 0};

    rst_N = 1'b0;
    idle();
    repeat (3) @(negedge clK);

    // Reset state
    chk("rst busy",    16'(busy[0]), 16'd1);
    chk("rst u0 a_v",  16'(a_v[0]),  16'd0);
    chk("rst u0 a_do", a_do[0],      16'h0000);
    chk("rst u2 b_do", b_do[2],      16'h0000);
    chk("rst u0 col",  16'(col[0]),  16'd0);

    // Initial fill: busy for exactly 32 cycles, quiet while busy
    rst_N = 1'b1;
    count_busy(n, noisy);
    chk("init busy cycles", 16'(n), 16'd32);
    chk("init quiet", 16'(noisy), 16'd0);

    // Vector table; u[2] lags u[0] by one cycle in read-first terms
    prev = '{default: '0};
    for (int k = 0; k < NV; k++) begin
      drive(tbl[k]);
      @(negedge clK);
      chk($sformatf("v%0d u0 a_v", k),   16'(a_v[0]), 16'(tbl[k].xa_vld));
      chk($sformatf("v%0d u0 a_do", k),  a_do[0],     tbl[k].xa0);
      chk($sformatf("v%0d u0 b_v", k),   16'(b_v[0]), 16'(tbl[k].xb_vld));
      chk($sformatf("v%0d u0 b_do", k),  b_do[0],     tbl[k].xb0);
      chk($sformatf("v%0d u0 col", k),   16'(col[0]), 16'(tbl[k].xcol));
      chk($sformatf("v%0d u1 a_do", k),  a_do[1],     tbl[k].xa1);
      chk($sformatf("v%0d u1 b_do", k),  b_do[1],     tbl[k].xb1);
      chk($sformatf("v%0d u1 col", k),   16'(col[1]), 16'(tbl[k].xcol));
      chk($sformatf("v%0d u2 a_v", k),   16'(a_v[2]), 16'(prev.xa_vld));
      chk($sformatf("v%0d u2 a_do", k),  a_do[2],     prev.xa0);
      chk($sformatf("v%0d u2 b_v", k),   16'(b_v[2]), 16'(prev.xb_vld));
      chk($sformatf("v%0d u2 b_do", k),  b_do[2],     prev.xb0);
      chk($sformatf("v%0d u2 col", k),   16'(col[2]), 16'(prev.xcol));
      prev = tbl[k];
    end
    idle();
    @(negedge clK);
    chk("tail u2 b_v",  16'(b_v[2]), 16'd0);
    chk("tail u2 b_do", b_do[2],     16'h0013);

    // Reset during RUN drops an in-flight read
    a_en = 1; a_addr = 5'd3;
    @(negedge clK);
    chk("inflight u0 a_v",  16'(a_v[0]), 16'd1);
    chk("inflight u0 a_do", a_do[0],     16'h0013);
    rst_N = 1'b0;
    @(negedge clK);
    chk("drop u0 a_v",  16'(a_v[0]), 16'd0);
    chk("drop u0 a_do", a_do[0],     16'h0000);
    chk("drop u2 a_v",  16'(a_v[2]), 16'd0);
    chk("drop u2 a_do", a_do[2],     16'h0000);
    chk("drop busy",    16'(busy[0]), 16'd1);

    // Writes attempted throughout INIT, reset pulsed at INIT cycle 10
    a_en = 1; a_wr = 1; a_be = 2'b11; a_addr = 5'd0; a_din = 16'hFFFF;
    b_en = 1; b_wr = 1; b_be = 2'b11; b_addr = 5'd1; b_din = 16'hEEEE;
    rst_N = 1'b1;
    repeat (10) @(negedge clK);
    rst_N = 1'b0;
    @(negedge clK);
    rst_N = 1'b1;
    count_busy(n, noisy);
    idle();
    chk("reinit busy cycles", 16'(n), 16'd32);
    chk("reinit quiet", 16'(noisy), 16'd0);

    a_en = 1; a_addr = 5'd0; b_en = 1; b_addr = 5'd1;
    @(negedge clK);
    chk("post a0 u0", a_do[0], 16'h0000);
    chk("post b1 u0", b_do[0], 16'h0000);
    chk("post b1 u0 v", 16'(b_v[0]), 16'd1);
    chk("post col", 16'(col[0]), 16'd0);
    a_addr = 5'd3; b_addr = 5'd7;
    @(negedge clK);
    chk("post a3 u1", a_do[1], 16'h0000);
    chk("post b7 u1", b_do[1], 16'h0000);
    idle();
    @(negedge clK);
    chk("post a0 u2", a_do[2], 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dpram_be_init.md
Name: dpram_be_init

Overview:
Parametrised true dual-port synchronous RAM, the next generation of the team's FIFO storage primitive. Adds per-port enables, byte-lane write enables, and a selectable same-port read-during-write mode. Also adds deterministic cross-port collision resolution with a flag, an optional output pipeline register, and a self-clearing init sequencer that fills memory after reset. Sits under the FIFO controllers as their storage array.

Parameters:
DATA, 16, word width in bits; must be a multiple of BYTE.
ADDR, 5, address width; depth = 2**ADDR.
BYTE, 8, byte-lane width; lanes = DATA/BYTE.
RDW_MODE, 0, same-port read-during-write: 0 = read-first (old data), 1 = write-first (new data).
OUT_REG, 0, 1 adds one output register stage.
INIT_VAL, 0, value written to every word by the init sequence.

Ports:
clK  in  1  clock; all logic on the rising edge.
rst_N  in  1  synchronous active-low reset.
init_busy  out  1  high while the init sequence runs.
a_port_EN / b_port_EN  in  1  access enable.
a_port_WR / b_port_WR  in  1  write qualifier; only valid when EN is high.
a_port_BE / b_port_BE  in  DATA/BYTE  byte-lane write enables.
a_port_ADDR / b_port_ADDR  in  ADDR  word address.
a_port_data_IN / b_port_data_IN  in  DATA  write data.
a_port_data_OUT / b_port_data_OUT  out  DATA  read data.
a_port_VALID / b_port_VALID  out  1  read data valid, one-cycle pulse.
collision  out  1  cross-port same-address access flag, one-cycle pulse.

Behaviour:
- Reset (rst_N=0 at a clK edge): state=INIT, init counter=0. init_busy=1, all data_OUT=0, VALID=0, collision=0. Reset does not clear memory directly; the init sequence does.
- INIT: one word per cycle, write INIT_VAL at address counter 0..2**ADDR-1. After writing the last word, go to RUN; init_busy falls the cycle after the last write (2**ADDR cycles of busy after reset release).
- During INIT, EN on both ports is ignored: no writes, VALID stays 0, collision stays 0.
- Reset asserted mid-INIT or mid-RUN restarts INIT from address 0; in-flight reads are dropped and VALID is forced to 0.
- RUN, EN=1: a read always occurs.
  - OUT_REG=0: data_OUT and VALID update 1 cycle after the EN edge.
  - OUT_REG=1: they update 2 cycles after it. Fully pipelined, one access per port per cycle.
- data_OUT holds its last value when there is no read.
- Writes (EN=1, WR=1): only lanes with BE[i]=1 are updated. BE=0 with WR=1 is a pure read.
- Same-port read-during-write:
  - RDW_MODE=0 returns the pre-write word.
  - RDW_MODE=1 returns a per-lane merge: new data on enabled lanes, old data on the rest.
- Cross-port, both EN=1, same address, at least one WR=1:
  - collision pulses, aligned with that access's VALID (same latency).
  - Both write: port A wins on overlapping lanes; each port's non-overlapping lanes are written as enabled.
  - The read data of a port not writing that cycle is the old word (read-first), regardless of RDW_MODE.
  - The read data of a writing port follows RDW_MODE using its own write data only.
- Both ports reading the same address with no write: no collision.
- Address wrap: none; ADDR covers the full depth exactly.

Decomposition:
- Package dpram_pkg:
  - state encoding ST_INIT, ST_RUN.
  - RDW_READ_FIRST=0, RDW_WRITE_FIRST=1.
  - a lanes function (DATA/BYTE).
  - a byte-merge function (old, new, be) used by both ports.
- Sub-module dpram_init_seq: INIT/RUN FSM plus address counter. Outputs init_busy, init write enable, init address.
- Memory array, per-port lane logic, collision compare and output pipeline stay in the top.

Test Plan:
1. All tests use DATA=16, ADDR=5, INIT_VAL=0.
   - Release rst_N -> init_busy high for exactly 32 cycles.
   - Then A reads addr 31 -> a_port_data_OUT=0x0000 with a_port_VALID one cycle after EN.
2. A writes addr 3 0xABCD BE=11, then 0x1234 BE=01; A reads addr 3 -> 0xAB34.
3. Addr 5 holds 0x1111; A writes 0x2222 BE=11.
   - RDW_MODE=0 -> same-cycle read returns 0x1111.
   - RDW_MODE=1 -> returns 0x2222.
   - Next read returns 0x2222 in both modes.
4. Same cycle, addr 7 (init 0x0000): A writes 0xAAAA BE=01, B writes 0xBBBB BE=11.
   - collision pulses once.
   - B out=0x0000.
   - Subsequent read of addr 7 -> 0xBBAA.
5. rst_N low for 1 cycle at INIT cycle 10, with port writes attempted during busy.
   - init_busy stays high 32 cycles after re-release.
   - Attempted writes do not land; all reads return 0x0000.
6. OUT_REG=1: preload addrs 0..3 with 0x0010..0x0013, issue back-to-back reads 0..3 on B.
   - VALID high for 4 consecutive cycles starting 2 cycles after the first EN.
   - Data 0x0010..0x0013 in order.
